// File: rtl/accum_tile_write_scheduler_if.sv
// Handshake/bus bundle between the systolic output stage and the accumulator write scheduler.
// Tile-count and index widths are derived from the same parameters as the scheduler.
interface accum_tile_write_scheduler_if #(
    parameter int MAX_OUT_ROWS = 128,
    parameter int MAX_OUT_COLS = 128,
    parameter int SYS_ARR_ROWS = 16,
    parameter int SYS_ARR_COLS = 16
);
    localparam int RT_W = $clog2(MAX_OUT_ROWS / SYS_ARR_ROWS);
    localparam int CT_W = $clog2(MAX_OUT_COLS / SYS_ARR_COLS);
    localparam int SR_W = $clog2(SYS_ARR_ROWS);

    logic            start;
    logic [RT_W-1:0] num_row_tiles_m1;
    logic [CT_W-1:0] num_col_tiles_m1;
    logic            row_valid;
    logic            wr_en;
    logic [SR_W-1:0] sub_row;
    logic [RT_W-1:0] submat_row_idx;
    logic [CT_W-1:0] submat_col_idx;
    logic            busy;
    logic            done;
    logic            err;

    modport master (
        output start, num_row_tiles_m1, num_col_tiles_m1, row_valid,
        input  wr_en, sub_row, submat_row_idx, submat_col_idx, busy, done, err
    );

    modport slave (
        input  start, num_row_tiles_m1, num_col_tiles_m1, row_valid,
        output wr_en, sub_row, submat_row_idx, submat_col_idx, busy, done, err
    );
endinterface

// File: rtl/accum_tile_write_scheduler.sv
// Walks row tile / column tile / sub-row for one output pass, drains the write skew, pulses done.
// Optional protocol checker enabled by defining ACCUM_TILE_SCHED_PROTO_CHK_EN.
module accum_tile_write_scheduler #(
    parameter int MAX_OUT_ROWS = 128,
    parameter int MAX_OUT_COLS = 128,
    parameter int SYS_ARR_ROWS = 16,
    parameter int SYS_ARR_COLS = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    accum_tile_write_scheduler_if.slave     bus
);
    localparam int RT_W = $clog2(MAX_OUT_ROWS / SYS_ARR_ROWS);
    localparam int CT_W = $clog2(MAX_OUT_COLS / SYS_ARR_COLS);
    localparam int SR_W = $clog2(SYS_ARR_ROWS);
    localparam int DR_W = (SYS_ARR_COLS > 1) ? $clog2(SYS_ARR_COLS) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [SR_W-1:0] SR_LAST = SR_W'(SYS_ARR_ROWS - 1);
    localparam logic [DR_W-1:0] DR_LAST = DR_W'(SYS_ARR_COLS - 1);

    logic [1:0]      state;
    logic [RT_W-1:0] row_lat, row_cnt, row_q;
    logic [CT_W-1:0] col_lat, col_cnt, col_q;
    logic [SR_W-1:0] sr_cnt, sr_q;
    logic [DR_W-1:0] dr_cnt;
    logic            wr_en_q, busy_q, done_q;
    logic            last_sub, last_col, final_wr;

    assign last_sub = (sr_cnt == SR_LAST);
    assign last_col = (col_cnt == col_lat);
    assign final_wr = last_sub && last_col && (row_cnt == row_lat);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            row_lat <= '0;
            col_lat <= '0;
            row_cnt <= '0;
            col_cnt <= '0;
            sr_cnt  <= '0;
            dr_cnt  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            sr_q    <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        row_lat <= bus.num_row_tiles_m1;
                        col_lat <= bus.num_col_tiles_m1;
                        row_cnt <= '0;
                        col_cnt <= '0;
                        sr_cnt  <= '0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (bus.row_valid) begin
                        wr_en_q <= 1'b1;
                        sr_q    <= sr_cnt;
                        col_q   <= col_cnt;
                        row_q   <= row_cnt;
                        if (final_wr) begin
                            dr_cnt <= '0;
                            state  <= DRAIN;
                        end else if (last_sub) begin
                            // Sub-row wraps into the next column tile, column wraps into the next row tile.
                            sr_cnt <= '0;
                            if (last_col) begin
                                col_cnt <= '0;
                                row_cnt <= row_cnt + 1'b1;
                            end else begin
                                col_cnt <= col_cnt + 1'b1;
                            end
                        end else begin
                            sr_cnt <= sr_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // The final write's cycle is the first drain cycle, so done lands one skew depth after it.
                    if (dr_cnt == DR_LAST) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        dr_cnt <= dr_cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.wr_en          = wr_en_q;
    assign bus.sub_row        = sr_q;
    assign bus.submat_row_idx = row_q;
    assign bus.submat_col_idx = col_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;

`ifdef ACCUM_TILE_SCHED_PROTO_CHK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if ((bus.row_valid && state != RUN) || (bus.start && busy_q)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_accum_tile_write_scheduler.sv
// Scoreboard bench for accum_tile_write_scheduler: expected writes and their cycles are queued
// by the stimulus, a negedge monitor pops and compares them and checks done/busy timing.
module tb_accum_tile_write_scheduler;
    localparam int MOR  = 128;
    localparam int MOC  = 128;
    localparam int SAR  = 16;
    localparam int SAC  = 16;
    localparam int RT_W = $clog2(MOR / SAR);
    localparam int CT_W = $clog2(MOC / SAC);
    localparam int SR_W = $clog2(SAR);
`ifdef ACCUM_TILE_SCHED_PROTO_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct packed {
        logic [RT_W-1:0] r;
        logic [CT_W-1:0] c;
        logic [SR_W-1:0] s;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    accum_tile_write_scheduler_if #(
        .MAX_OUT_ROWS(MOR), .MAX_OUT_COLS(MOC), .SYS_ARR_ROWS(SAR), .SYS_ARR_COLS(SAC)
    ) bus ();

    accum_tile_write_scheduler #(
        .MAX_OUT_ROWS(MOR), .MAX_OUT_COLS(MOC), .SYS_ARR_ROWS(SAR), .SYS_ARR_COLS(SAC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    wr_t exp_q[$];
    int  t_q[$];
    int  nvec = 0;
    int  nfail = 0;
    int  cyc = 0;
    int  due = -1;
    bit  pass_active = 1'b0;
    bit  exp_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expected write per observed wr_en and tracks the done deadline.
    always @(negedge clk) begin
        wr_t e;
        int  t;
        if (reset) begin
            if (exp_q.size() == 0) begin
                chk("spurious_wr_en", bus.wr_en, 0);
            end else if (bus.wr_en) begin
                e = exp_q.pop_front();
                t = (t_q.size() != 0) ? t_q.pop_front() : -1;
                chk("wr_row_idx", bus.submat_row_idx, e.r);
                chk("wr_col_idx", bus.submat_col_idx, e.c);
                chk("wr_sub_row", bus.sub_row, e.s);
                chk("wr_cycle", cyc, t);
                if (exp_q.size() == 0 && pass_active) due = cyc + SAC;
            end
            if (pass_active && due >= 0 && cyc == due) begin
                chk("done_pulse", bus.done, 1);
                chk("busy_at_done", bus.busy, 0);
                pass_active = 1'b0;
                due = -1;
            end else begin
                chk("spurious_done", bus.done, 0);
                if (pass_active && due >= 0) chk("busy_in_drain", bus.busy, 1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        bus.start = 1'b0;
        bus.row_valid = 1'b0;
        repeat (n) step();
        exp_q.delete();
        t_q.delete();
        pass_active = 1'b0;
        due = -1;
        exp_err = 1'b0;
        reset = 1'b1;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_wr_en"}, bus.wr_en, 0);
        chk({tag, "_sub_row"}, bus.sub_row, 0);
        chk({tag, "_row_idx"}, bus.submat_row_idx, 0);
        chk({tag, "_col_idx"}, bus.submat_col_idx, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err"}, bus.err, exp_err);
    endtask

    // Reference order: row tile outermost, then column tile, then sub-row.
    task automatic begin_pass(input int rr, input int cc);
        wr_t e;
        for (int r = 0; r <= rr; r++)
            for (int c = 0; c <= cc; c++)
                for (int s = 0; s < SAR; s++) begin
                    e.r = RT_W'(r);
                    e.c = CT_W'(c);
                    e.s = SR_W'(s);
                    exp_q.push_back(e);
                end
        pass_active = 1'b1;
        due = -1;
        bus.num_row_tiles_m1 = RT_W'(rr);
        bus.num_col_tiles_m1 = CT_W'(cc);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        bus.num_row_tiles_m1 = RT_W'($urandom);
        bus.num_col_tiles_m1 = CT_W'($urandom);
    endtask

    // mode 0: always valid, 1: pattern 1,0,0, 2: random gaps. start_at pulses start with that row.
    task automatic feed(input int n, input int mode, input int start_at);
        int sent = 0;
        int i = 0;
        bit v;
        while (sent < n && i < 10 * n + 10) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (i % 3 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            if (v) begin
                bus.row_valid = 1'b1;
                t_q.push_back(cyc + 1);
                sent++;
                if (sent == start_at) begin
                    bus.start = 1'b1;
                    exp_err |= CHK;
                end
            end else begin
                bus.row_valid = 1'b0;
            end
            step();
            bus.start = 1'b0;
            i++;
        end
        bus.row_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (pass_active && n < 300) begin
            step();
            n++;
        end
        chk("pass_completes", pass_active, 0);
        pass_active = 1'b0;
    endtask

    initial begin
        int rr, cc;
        bus.start = 1'b0;
        bus.row_valid = 1'b0;
        bus.num_row_tiles_m1 = '0;
        bus.num_col_tiles_m1 = '0;

        do_reset(3);
        check_quiet("reset");
        for (int k = 0; k < 4; k++) begin
            bus.row_valid = (k % 2 == 0);
            step();
        end
        bus.row_valid = 1'b0;
        exp_err |= CHK;
        step();
        check_quiet("idle_rv");
        do_reset(2);

        begin_pass(0, 0);
        feed(16, 0, -1);
        wait_done();

        begin_pass(0, 0);
        feed(16, 1, -1);
        wait_done();

        begin_pass(1, 1);
        feed(64, 0, -1);
        wait_done();

        for (int k = 0; k < 2; k++) begin
            rr = $urandom_range(0, 2);
            cc = $urandom_range(0, 2);
            begin_pass(rr, cc);
            feed((rr + 1) * (cc + 1) * SAR, 2, -1);
            wait_done();
        end

        begin_pass(1, 1);
        feed(30, 0, 20);
        do_reset(2);
        check_quiet("mid_reset");
        repeat (SAC + 4) step();

        begin_pass(0, 0);
        feed(16, 0, -1);
        bus.row_valid = 1'b1;
        step();
        bus.row_valid = 1'b0;
        exp_err |= CHK;
        step();
        chk("err_after_drain_rv", bus.err, exp_err);
        wait_done();
        chk("err_sticky", bus.err, exp_err);
        do_reset(2);
        chk("err_after_reset", bus.err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/accum_tile_write_scheduler.md
Name: accum_tile_write_scheduler

Overview:
- Sequences the accumulator-table write controller for one output-matrix pass.
- Walks sub-matrix row index, sub-matrix column index and sub-row in a fixed order, and issues one write strobe per valid systolic-array output row.
- Drains the per-column write skew of the write controller, then reports completion with a done pulse.
- Sits between the systolic-array output stage and the accumulator-table write controller; its outputs feed that controller's wr_en_in, sub_row, submat_row_idx and submat_col_idx inputs.

Parameters:
- MAX_OUT_ROWS, 128, maximum output-matrix rows.
- MAX_OUT_COLS, 128, maximum output-matrix columns.
- SYS_ARR_ROWS, 16, systolic-array rows, which is also the number of sub-rows per tile.
- SYS_ARR_COLS, 16, systolic-array columns, which is also the write-skew depth.

Derived widths:
- RT_W = $clog2(MAX_OUT_ROWS/SYS_ARR_ROWS)
- CT_W = $clog2(MAX_OUT_COLS/SYS_ARR_COLS)
- SR_W = $clog2(SYS_ARR_ROWS)

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- start  input  1  one-cycle request to begin a pass; sampled only in IDLE.
- num_row_tiles_m1  input  RT_W  number of sub-matrix rows minus 1; latched on an accepted start.
- num_col_tiles_m1  input  CT_W  number of sub-matrix columns minus 1; latched on an accepted start.
- row_valid  input  1  the systolic array presents one output row this cycle.
- wr_en  output  1  write strobe to the write controller.
- sub_row  output  SR_W  sub-row index of the current write.
- submat_row_idx  output  RT_W  sub-matrix row index of the current write.
- submat_col_idx  output  CT_W  sub-matrix column index of the current write.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse at the end of a pass.
- err  output  1  sticky protocol error flag (see Optional Feature).

Behaviour:
- Reset (reset=0 at a clock edge):
  - State goes to IDLE.
  - wr_en, sub_row, submat_row_idx, submat_col_idx, busy, done and err all go to 0.
  - The latched tile counts clear to 0.
  - Reset applied mid-pass aborts the pass immediately: no done pulse, and no further wr_en.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 latches both tile counts, clears the counters and moves to RUN. start in any other state is ignored.
  - RUN: each cycle with row_valid=1 issues one write. row_valid=0 issues nothing and holds the counters.
  - RUN to DRAIN: in the cycle that issues the final write (sub_row = SYS_ARR_ROWS-1, row index = latched row count, column index = latched column count).
  - DRAIN: counts exactly SYS_ARR_COLS cycles, then moves to DONE.
  - DONE: lasts one cycle with done=1, then returns to IDLE.
- Issue timing (registered outputs):
  - A write accepted at cycle T produces wr_en=1 at T+1, with the indices of that write, all registered.
  - Indices hold their last value whenever wr_en=0.
- Counter order, innermost first:
  - sub_row counts 0 to SYS_ARR_ROWS-1 and wraps to 0.
  - On sub_row wrap, submat_col_idx increments up to the latched column count, then wraps to 0.
  - On column wrap, submat_row_idx increments.
  - Counters are not reachable beyond the latched counts.
- Done timing:
  - The final wr_en is high at cycle F.
  - DRAIN covers F through F+SYS_ARR_COLS-1.
  - done=1 and busy=0 at cycle F+SYS_ARR_COLS, which covers the last column write of the downstream shift register.
- busy:
  - High in RUN and DRAIN.
  - Low in IDLE and DONE.
- Total writes per pass = (rows+1)*(cols+1)*SYS_ARR_ROWS.

Optional Feature:
- Macro: ACCUM_TILE_SCHED_PROTO_CHK_EN.
- Defined:
  - err is set when row_valid=1 in IDLE, DRAIN or DONE.
  - err is also set when start=1 while busy=1.
  - err is sticky and cleared only by reset. The offending input is still ignored.
- Undefined: err is tied to 0, and no checker logic is present.

Test Plan:
- Reset and idle: hold reset=0 for 3 cycles, then release → every output reads 0. Toggling row_valid in IDLE gives wr_en=0.
- Single tile: start with row count 0 and column count 0, then row_valid=1 for 16 cycles → 16 wr_en pulses with sub_row 0..15 and both tile indices 0. busy goes low and done pulses exactly 16 cycles after the last wr_en.
- Gapped input on a 1x1 pass: row_valid follows the pattern 1,0,0,1,... → wr_en pulses only one cycle after each valid row, sub_row has no skipped values, and the total is 16 writes.
- 2x2 ordering: row count 1, column count 1, row_valid held high → 64 writes in the order (r0,c0,s0..15), (r0,c1,...), (r1,c0,...), (r1,c1,s15), followed by done.
- Reset mid-pass and ignored start: pulse start after 20 writes → no effect. Then drive reset=0 at write 30 → all outputs 0 on the next cycle and no done. A fresh start then begins again at index 0/0/0.
- Protocol check with ACCUM_TILE_SCHED_PROTO_CHK_EN defined: row_valid=1 during DRAIN → err=1 and it stays set until reset. With the macro undefined, the same stimulus leaves err=0.
